ctrl_pipeline_hazard: RTL and testbench

- Consumes the 13-bit decoded control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Selects the destination register per stage and resolves conditional branches in EX.
- Detects load-use hazards, producing stall and bubble controls, and issues flushes for jumps and taken branches.
- Generates forwarding selects for the two EX ALU operands.
- Sits between the opcode decoder and the datapath pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 51 +++++
 rtl/forward_unit.sv | 35 +++
 rtl/ctrl_pipeline_hazard.sv | 125 ++++++++++++
 tb/tb_ctrl_pipeline_hazard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle layout, register-index widths and select encodings for the
// pipeline control path and the opcode decoder.
package pipe_ctrl_pkg;

    localparam int unsigned CTRL_W = 13;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] RA_REG = 5'd31;

    // Bundle bit positions, MSB to LSB.
    localparam int unsigned CTRL_REGDST_HI   = 12;
    localparam int unsigned CTRL_REGDST_LO   = 11;
    localparam int unsigned CTRL_JUMP        = 10;
    localparam int unsigned CTRL_BRANCH      = 9;
    localparam int unsigned CTRL_BRTYPE      = 8;
    localparam int unsigned CTRL_MEMREAD     = 7;
    localparam int unsigned CTRL_MEMTOREG_HI = 6;
    localparam int unsigned CTRL_MEMTOREG_LO = 5;
    localparam int unsigned CTRL_MEMWRITE    = 4;
    localparam int unsigned CTRL_ALUSRC      = 3;
    localparam int unsigned CTRL_REGWRITE    = 2;
    localparam int unsigned CTRL_ALUOP_HI    = 1;
    localparam int unsigned CTRL_ALUOP_LO    = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    typedef enum logic [1:0] {
        RegDstRt   = 2'b00,
        RegDstRd   = 2'b01,
        RegDstRa   = 2'b10,
        RegDstZero = 2'b11
    } regdst_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    function automatic regdst_e regdst_of(ctrl_t c);
        return regdst_e'(c[CTRL_REGDST_HI:CTRL_REGDST_LO]);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational ALU operand forwarding selects; the EX/MEM result wins over MEM/WB.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             mem_regwrite_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             wb_regwrite_i,
    input  logic [REG_W-1:0] wb_dest_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    function automatic logic [1:0] fwd_sel(
        logic [REG_W-1:0] src,
        logic             mem_we,
        logic [REG_W-1:0] mem_dst,
        logic             wb_we,
        logic [REG_W-1:0] wb_dst
    );
        if (mem_we && (mem_dst != '0) && (mem_dst == src)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_o = fwd_sel(ex_rs_i, mem_regwrite_i, mem_dest_i, wb_regwrite_i, wb_dest_i);
        fwd_b_o = fwd_sel(ex_rt_i, mem_regwrite_i, mem_dest_i, wb_regwrite_i, wb_dest_i);
    end

endmodule

// File: rtl/ctrl_pipeline_hazard.sv
// Control-side ID/EX, EX/MEM, MEM/WB registers with load-use stall, branch/jump flush
// and operand forwarding selects.
module ctrl_pipeline_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_zero,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dest,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [REG_W-1:0]  mem_dest,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_W-1:0]  wb_dest,
    output logic              branch_taken,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0]  ex_rs_q, ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q, ex_rt_d;
    logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
    logic [REG_W-1:0]  mem_dest_q, mem_dest_d;
    logic [CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;
    logic [REG_W-1:0]  wb_dest_q, wb_dest_d;

    logic             load_use;
    logic             bubble;
    logic [REG_W-1:0] ex_dest_w;

    always_comb begin
        ex_dest_w = '0;
        unique case (regdst_of(ex_ctrl_q))
            RegDstRt:   ex_dest_w = ex_rt_q;
            RegDstRd:   ex_dest_w = ex_rd_q;
            RegDstRa:   ex_dest_w = RA_REG;
            RegDstZero: ex_dest_w = '0;
            default:    ex_dest_w = '0;
        endcase
    end

    always_comb begin
        branch_taken = ex_ctrl_q[CTRL_BRANCH] & (ex_zero ^ ex_ctrl_q[CTRL_BRTYPE]);
        load_use     = ex_ctrl_q[CTRL_MEMREAD] && (ex_rt_q != '0) &&
                       ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
        // A taken branch squashes the ID instruction anyway, so it cancels the stall.
        stall        = load_use & ~branch_taken;
        bubble       = stall | branch_taken;
        pc_write     = ~stall;
        ifid_write   = ~stall;
        ifid_flush   = id_ctrl[CTRL_JUMP] | branch_taken;
    end

    always_comb begin
        mem_ctrl_d = ex_ctrl_q;
        mem_dest_d = ex_dest_w;
        wb_ctrl_d  = mem_ctrl_q;
        wb_dest_d  = mem_dest_q;
        ex_ctrl_d  = id_ctrl;
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_rd_d    = id_rd;
        if (bubble) begin
            ex_ctrl_d = '0;
            ex_rs_d   = '0;
            ex_rt_d   = '0;
            ex_rd_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_dest_q <= '0;
            wb_ctrl_q  <= '0;
            wb_dest_q  <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_dest_q <= mem_dest_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_dest_q  <= wb_dest_d;
        end
    end

    forward_unit u_forward_unit (
        .ex_rs_i        (ex_rs_q),
        .ex_rt_i        (ex_rt_q),
        .mem_regwrite_i (mem_ctrl_q[CTRL_REGWRITE]),
        .mem_dest_i     (mem_dest_q),
        .wb_regwrite_i  (wb_ctrl_q[CTRL_REGWRITE]),
        .wb_dest_i      (wb_dest_q),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    assign ex_ctrl  = ex_ctrl_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_dest  = ex_dest_w;
    assign mem_ctrl = mem_ctrl_q;
    assign mem_dest = mem_dest_q;
    assign wb_ctrl  = wb_ctrl_q;
    assign wb_dest  = wb_dest_q;

endmodule

// File: tb/tb_ctrl_pipeline_hazard.sv
// Self-checking bench: vector table, hand-written corner sequences and random stimulus
// against an instruction-level model of the three pipeline stages.
module tb_ctrl_pipeline_hazard;

    localparam logic [12:0] NOP  = 13'h0000;
    localparam logic [12:0] LW   = 13'h00AC;
    localparam logic [12:0] ADD  = 13'h0806;
    localparam logic [12:0] BEQ  = 13'h0201;
    localparam logic [12:0] BNE  = 13'h0301;
    localparam logic [12:0] JAL  = 13'h1444;
    localparam logic [12:0] ADDI = 13'h000C;
    localparam logic [12:0] SW   = 13'h0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_zero;
    logic [12:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        branch_taken, stall, pc_write, ifid_write, ifid_flush;
    logic [1:0]  fwd_a, fwd_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipeline_hazard dut (
        .clk          (clk),
        .reset        (reset),
        .id_ctrl      (id_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .ex_zero      (ex_zero),
        .ex_ctrl      (ex_ctrl),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dest      (ex_dest),
        .mem_ctrl     (mem_ctrl),
        .mem_dest     (mem_dest),
        .wb_ctrl      (wb_ctrl),
        .wb_dest      (wb_dest),
        .branch_taken (branch_taken),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // Model: one record per in-flight instruction; destinations derived on demand.
    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;
    bit     model_on = 0;

    function automatic logic [4:0] m_dest(instr_t i);
        case (i.ctrl[12:11])
            2'b00:   return i.rt;
            2'b01:   return i.rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] src);
        if (m_mem.ctrl[2] && m_dest(m_mem) != 0 && m_dest(m_mem) == src) return 2'b10;
        if (m_wb.ctrl[2] && m_dest(m_wb) != 0 && m_dest(m_wb) == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_taken();
        return m_ex.ctrl[9] && (ex_zero != m_ex.ctrl[8]);
    endfunction

    function automatic logic m_stall();
        return m_ex.ctrl[7] && m_ex.rt != 0 && (m_ex.rt == id_rs || m_ex.rt == id_rt)
               && !m_taken();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        if (!model_on) return;
        chk("m ex_ctrl",  32'(ex_ctrl),  32'(m_ex.ctrl));
        chk("m ex_rs",    32'(ex_rs),    32'(m_ex.rs));
        chk("m ex_rt",    32'(ex_rt),    32'(m_ex.rt));
        chk("m ex_dest",  32'(ex_dest),  32'(m_dest(m_ex)));
        chk("m mem_ctrl", 32'(mem_ctrl), 32'(m_mem.ctrl));
        chk("m mem_dest", 32'(mem_dest), 32'(m_dest(m_mem)));
        chk("m wb_ctrl",  32'(wb_ctrl),  32'(m_wb.ctrl));
        chk("m wb_dest",  32'(wb_dest),  32'(m_dest(m_wb)));
        chk("m taken",    32'(branch_taken), 32'(m_taken()));
        chk("m stall",    32'(stall),      32'(m_stall()));
        chk("m pc_write", 32'(pc_write),   32'(!m_stall()));
        chk("m ifid_wr",  32'(ifid_write), 32'(!m_stall()));
        chk("m flush",    32'(ifid_flush), 32'(id_ctrl[10] || m_taken()));
        chk("m fwd_a",    32'(fwd_a),      32'(m_fwd(m_ex.rs)));
        chk("m fwd_b",    32'(fwd_b),      32'(m_fwd(m_ex.rt)));
    endtask

    task automatic model_update();
        logic squash;
        squash = m_stall() || m_taken();
        if (reset) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = squash ? instr_t'('0) : instr_t'({id_ctrl, id_rs, id_rt, id_rd});
        end
    endtask

    task automatic drive(input logic r, input logic [12:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic z);
        reset = r; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
        #2;
    endtask

    task automatic tick();
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, NOP, 0, 0, 0, 1'b0);
        tick();
    endtask

    task automatic fwd_case(input string name, input logic [12:0] cx, input logic [4:0] dx,
                            input logic [12:0] cy, input logic [4:0] dy, input logic [4:0] src,
                            input logic [1:0] exp);
        do_reset();
        drive(1'b0, cx, 0, 0, dx, 1'b0); tick();
        drive(1'b0, cy, 0, 0, dy, 1'b0); tick();
        drive(1'b0, ADD, src, src, 5'd6, 1'b0); tick();
        drive(1'b0, NOP, 0, 0, 0, 1'b0);
        chk({name, " fwd_a"}, 32'(fwd_a), 32'(exp));
        chk({name, " fwd_b"}, 32'(fwd_b), 32'(exp));
    endtask

    typedef struct {
        logic [12:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic        zero;
        logic        e_stall, e_flush, e_taken;
        logic [1:0]  e_fa, e_fb;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t tbl[10];
    logic [12:0] pool[8];

    initial begin
        tbl[0] = '{LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[1] = '{ADD, 5'd8, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd8};
        tbl[2] = '{ADD, 5'd8, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[3] = '{NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd9};
        tbl[4] = '{BNE, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[5] = '{ADD, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 5'd0};
        tbl[6] = '{BEQ, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[7] = '{NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[8] = '{JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd0};
        tbl[9] = '{NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd31};
        pool = '{NOP, LW, ADD, BEQ, BNE, JAL, ADDI, SW};

        // Reset held two cycles with every control bit set in ID.
        drive(1'b1, 13'h1FFF, 0, 0, 0, 1'b0);
        @(posedge clk);
        model_update();
        model_on = 1;
        #1;
        drive(1'b1, 13'h1FFF, 0, 0, 0, 1'b0);
        chk("rst ex_ctrl",  32'(ex_ctrl), 0);
        chk("rst mem_ctrl", 32'(mem_ctrl), 0);
        chk("rst wb_ctrl",  32'(wb_ctrl), 0);
        chk("rst stall",    32'(stall), 0);
        chk("rst pc_write", 32'(pc_write), 1);
        chk("rst flush",    32'(ifid_flush), 1);
        tick();

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].zero);
            chk($sformatf("tbl%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d pc_write", i), 32'(pc_write), 32'(!tbl[i].e_stall));
            chk($sformatf("tbl%0d flush", i), 32'(ifid_flush), 32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d taken", i), 32'(branch_taken), 32'(tbl[i].e_taken));
            chk($sformatf("tbl%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].e_fa));
            chk($sformatf("tbl%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].e_fb));
            chk($sformatf("tbl%0d ex_dest", i), 32'(ex_dest), 32'(tbl[i].e_dest));
            tick();
        end

        // LW reaches WB three edges after leaving ID.
        do_reset();
        drive(1'b0, LW, 5'd0, 5'd8, 5'd0, 1'b0); tick();
        drive(1'b0, NOP, 0, 0, 0, 1'b0); tick(); tick();
        chk("pass wb_ctrl", 32'(wb_ctrl), 32'(13'h00AC));
        chk("pass wb_dest", 32'(wb_dest), 8);

        fwd_case("prio both", ADD, 5'd5, ADD, 5'd5, 5'd5, 2'b10);
        fwd_case("prio memoff", ADD, 5'd5, 13'h0800, 5'd5, 5'd5, 2'b01);
        fwd_case("prio zero", ADD, 5'd0, ADD, 5'd0, 5'd0, 2'b00);

        // Taken branch that also looks like a load-use, with JAL in ID.
        do_reset();
        drive(1'b0, 13'h0381, 5'd0, 5'd8, 5'd0, 1'b0); tick();
        drive(1'b0, JAL, 5'd8, 5'd0, 5'd0, 1'b0);
        chk("conf stall", 32'(stall), 0);
        chk("conf pc_write", 32'(pc_write), 1);
        chk("conf flush", 32'(ifid_flush), 1);
        chk("conf taken", 32'(branch_taken), 1);
        tick();
        chk("conf bubble", 32'(ex_ctrl), 0);
        chk("conf mem_ctrl", 32'(mem_ctrl), 32'(13'h0381));
        drive(1'b0, JAL, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        drive(1'b0, NOP, 0, 0, 0, 1'b0);
        chk("jal ex_dest", 32'(ex_dest), 31);
        chk("jal ex_ctrl", 32'(ex_ctrl), 32'(JAL));
        tick();

        for (int n = 0; n < 600; n++) begin
            logic [12:0] c;
            c = ($urandom_range(0, 7) == 0) ? 13'($urandom) : pool[$urandom_range(0, 7)];
            drive(($urandom_range(0, 49) == 0), c, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
